// File: rtl/i2c_slave_addr_ctrl.sv
// I2C slave front end: pin synchronisers, START/STOP detection, 7-bit address
// receive/match with address ACK, and the enable window for the data-in decoder.
module i2c_slave_addr_ctrl #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic FPGA_clk,
  input  logic rst,
  input  logic SCL_in,
  input  logic SDA_in,
  input  logic data_done,
  output logic SCL,
  output logic SCL_prev,
  output logic SDA,
  output logic SDA_prev,
  output logic enable,
  output logic SDA_down,
  output logic start_det,
  output logic stop_det,
  output logic addr_match,
  output logic rw_bit,
  output logic bus_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    DATA,
    WAIT_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [7:0]             shift_q, shift_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   enable_q, enable_d;
  logic                   sda_down_q, sda_down_d;
  logic                   start_det_q, start_det_d;
  logic                   stop_det_q, stop_det_d;
  logic                   addr_match_q, addr_match_d;
  logic                   rw_bit_q, rw_bit_d;
  logic                   bus_busy_q, bus_busy_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], SCL_in};
    sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], SDA_in};
    scl_prev_d   = scl_s;
    sda_prev_d   = sda_s;
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    enable_d     = enable_q;
    sda_down_d   = sda_down_q;
    addr_match_d = addr_match_q;
    rw_bit_d     = rw_bit_q;
    bus_busy_d   = bus_busy_q;
    start_det_d  = start_c;
    stop_det_d   = stop_c;

    // START/STOP override everything else, including a coincident data_done.
    if (start_c) begin
      if (state_q != IDLE) begin
        addr_match_d = 1'b0;
      end
      state_d    = ADDR;
      bit_cnt_d  = 4'd0;
      enable_d   = 1'b0;
      sda_down_d = 1'b0;
      bus_busy_d = 1'b1;
    end else if (stop_c) begin
      state_d    = IDLE;
      enable_d   = 1'b0;
      sda_down_d = 1'b0;
      bus_busy_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              addr_match_d = (shift_d[7:1] == SLAVE_ADDR);
              rw_bit_d     = shift_d[0];
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (addr_match_q && !rw_bit_q) begin
              state_d    = ACK_ADDR;
              sda_down_d = 1'b1;
            end else begin
              state_d    = WAIT_STOP;
              sda_down_d = 1'b0;
            end
          end
        end
        ACK_ADDR: begin
          sda_down_d = 1'b1;
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_down_d = 1'b0;
            enable_d   = 1'b1;
            state_d    = DATA;
          end
        end
        DATA: begin
          enable_d   = 1'b1;
          sda_down_d = 1'b0;
          if (data_done) begin
            enable_d = 1'b0;
            state_d  = WAIT_STOP;
          end
        end
        WAIT_STOP: begin
          enable_d   = 1'b0;
          sda_down_d = 1'b0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      shift_q      <= 8'd0;
      bit_cnt_q    <= 4'd0;
      enable_q     <= 1'b0;
      sda_down_q   <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      addr_match_q <= 1'b0;
      rw_bit_q     <= 1'b0;
      bus_busy_q   <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      enable_q     <= enable_d;
      sda_down_q   <= sda_down_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      addr_match_q <= addr_match_d;
      rw_bit_q     <= rw_bit_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

  assign SCL        = scl_s;
  assign SCL_prev   = scl_prev_q;
  assign SDA        = sda_s;
  assign SDA_prev   = sda_prev_q;
  assign enable     = enable_q;
  assign SDA_down   = sda_down_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign addr_match = addr_match_q;
  assign rw_bit     = rw_bit_q;
  assign bus_busy   = bus_busy_q;

endmodule

// File: tb/tb_i2c_slave_addr_ctrl.sv
// Bench for i2c_slave_addr_ctrl: drives bit-level I2C master traffic and checks
// outputs against a transaction-level model of the slave's expected behaviour.
module tb_i2c_slave_addr_ctrl;
  localparam logic [6:0] SA = 7'h42;
  localparam int         SS = 2;
  localparam int         H  = 8;

  logic FPGA_clk = 1'b0;
  logic rst = 1'b1;
  logic SCL_in = 1'b1;
  logic SDA_in = 1'b1;
  logic data_done = 1'b0;
  logic SCL, SCL_prev, SDA, SDA_prev, enable, SDA_down;
  logic start_det, stop_det, addr_match, rw_bit, bus_busy;

  i2c_slave_addr_ctrl #(.SLAVE_ADDR(SA), .SYNC_STAGES(SS)) dut (
    .FPGA_clk(FPGA_clk), .rst(rst), .SCL_in(SCL_in), .SDA_in(SDA_in),
    .data_done(data_done), .SCL(SCL), .SCL_prev(SCL_prev), .SDA(SDA),
    .SDA_prev(SDA_prev), .enable(enable), .SDA_down(SDA_down),
    .start_det(start_det), .stop_det(stop_det), .addr_match(addr_match),
    .rw_bit(rw_bit), .bus_busy(bus_busy)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  int n_checks = 0;
  int n_fail = 0;
  // Transaction-level model of the slave
  int m_match = 0, m_rw = 0, m_busy = 0, m_en = 0;
  int start_cycles = 0, stop_cycles = 0, exp_starts = 0, exp_stops = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge FPGA_clk);
  endtask

  // Pulse monitor: each START/STOP must give exactly one cycle of detect.
  always @(negedge FPGA_clk) begin
    if (start_det === 1'b1) begin
      start_cycles++;
      chk("enable_on_start_det", int'(enable), 0);
      chk("sda_down_on_start_det", int'(SDA_down), 0);
    end
    if (stop_det === 1'b1) stop_cycles++;
  end

  task automatic check_reset(input string tag);
    $display("check reset values (%s)", tag);
    chk({tag, "_scl"}, int'(SCL), 1);
    chk({tag, "_scl_prev"}, int'(SCL_prev), 1);
    chk({tag, "_sda"}, int'(SDA), 1);
    chk({tag, "_sda_prev"}, int'(SDA_prev), 1);
    chk({tag, "_enable"}, int'(enable), 0);
    chk({tag, "_sda_down"}, int'(SDA_down), 0);
    chk({tag, "_start_det"}, int'(start_det), 0);
    chk({tag, "_stop_det"}, int'(stop_det), 0);
    chk({tag, "_addr_match"}, int'(addr_match), 0);
    chk({tag, "_rw_bit"}, int'(rw_bit), 0);
    chk({tag, "_bus_busy"}, int'(bus_busy), 0);
  endtask

  task automatic send_bit(input logic b);
    tick(2);
    SDA_in = b;
    tick(H - 2);
    SCL_in = 1'b1;
    tick(H);
    SCL_in = 1'b0;
  endtask

  task automatic do_start();
    int rep;
    rep = m_busy;
    if (rep != 0) begin
      SDA_in = 1'b1;
      tick(H);
      SCL_in = 1'b1;
      tick(H);
    end else begin
      SCL_in = 1'b1;
      SDA_in = 1'b1;
      tick(H);
    end
    SDA_in = 1'b0;
    tick(H);
    SCL_in = 1'b0;
    tick(2);
    exp_starts++;
    if (rep != 0) m_match = 0;
    m_busy = 1;
    m_en = 0;
    chk("start_det_cycles", start_cycles, exp_starts);
    chk("busy_after_start", int'(bus_busy), 1);
    chk("match_after_start", int'(addr_match), m_match);
    chk("enable_after_start", int'(enable), 0);
  endtask

  task automatic do_stop();
    SCL_in = 1'b0;
    tick(2);
    SDA_in = 1'b0;
    tick(H - 2);
    SCL_in = 1'b1;
    tick(H);
    SDA_in = 1'b1;
    tick(H);
    exp_stops++;
    m_busy = 0;
    m_en = 0;
    chk("stop_det_cycles", stop_cycles, exp_stops);
    chk("busy_after_stop", int'(bus_busy), 0);
    chk("enable_after_stop", int'(enable), 0);
    chk("sda_down_after_stop", int'(SDA_down), 0);
    chk("match_kept_after_stop", int'(addr_match), m_match);
    chk("rw_kept_after_stop", int'(rw_bit), m_rw);
  endtask

  task automatic send_addr(input logic [7:0] ab);
    int e_match, e_rw, e_ack;
    e_match = (ab[7:1] == SA) ? 1 : 0;
    e_rw    = int'(ab[0]);
    e_ack   = (e_match == 1 && e_rw == 0) ? 1 : 0;
    for (int i = 7; i >= 0; i--) send_bit(ab[i]);
    tick(2);
    SDA_in = 1'b1;
    tick(H - 2);
    chk("ack_sda_down_9th_low", int'(SDA_down), e_ack);
    chk("addr_match", int'(addr_match), e_match);
    chk("rw_bit", int'(rw_bit), e_rw);
    SCL_in = 1'b1;
    tick(H / 2);
    chk("ack_sda_down_9th_high", int'(SDA_down), e_ack);
    chk("enable_before_9th_fall", int'(enable), 0);
    tick(H / 2);
    SCL_in = 1'b0;
    tick(H);
    chk("sda_down_after_ack", int'(SDA_down), 0);
    chk("enable_after_9th_fall", int'(enable), e_ack);
    m_match = e_match;
    m_rw    = e_rw;
    m_en    = e_ack;
  endtask

  task automatic send_data(input logic [7:0] db);
    for (int i = 7; i >= 0; i--) send_bit(db[i]);
    tick(2);
    SDA_in = 1'b1;
    tick(H - 2);
    SCL_in = 1'b1;
    tick(H / 2);
    chk("data_enable", int'(enable), m_en);
    chk("data_sda_down", int'(SDA_down), 0);
    tick(H / 2);
    SCL_in = 1'b0;
    tick(2);
  endtask

  task automatic pulse_done();
    chk("enable_before_done", int'(enable), m_en);
    data_done = 1'b1;
    tick(1);
    data_done = 1'b0;
    chk("enable_after_done", int'(enable), 0);
    m_en = 0;
  endtask

  task automatic do_xfer(input logic [7:0] ab, input int nbytes, input int done_after,
                         input int partial, input bit do_stp);
    logic [7:0] db;
    do_start();
    send_addr(ab);
    for (int k = 0; k < nbytes; k++) begin
      db = 8'($urandom);
      send_data(db);
      if (k == done_after) pulse_done();
    end
    for (int k = 0; k < partial; k++) send_bit(1'($urandom_range(0, 1)));
    if (do_stp) do_stop();
    $display("xfer addr_byte=%02h bytes=%0d done_after=%0d partial=%0d stop=%0d checks=%0d fails=%0d",
             ab, nbytes, done_after, partial, do_stp, n_checks, n_fail);
  endtask

  task automatic do_reset_mid();
    logic [7:0] ab;
    ab = 8'h84;
    do_start();
    for (int i = 7; i >= 4; i--) send_bit(ab[i]);
    tick(2);
    SDA_in = ab[3];
    tick(H - 2);
    SCL_in = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    check_reset("mid_xfer_reset");
    tick(3);
    check_reset("mid_xfer_reset_held");
    SCL_in = 1'b1;
    SDA_in = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(H);
    m_match = 0;
    m_rw = 0;
    m_busy = 0;
    m_en = 0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    check_reset("power_on");
    tick(2);
    rst = 1'b1;
    tick(2);

    // Pin synchroniser latency
    SCL_in = 1'b0;
    tick(SS - 1);
    chk("sync_latency_not_yet", int'(SCL), 1);
    tick(1);
    chk("sync_latency_scl", int'(SCL), 0);
    chk("sync_latency_prev", int'(SCL_prev), 1);
    tick(1);
    chk("sync_latency_scl_prev", int'(SCL_prev), 0);
    SCL_in = 1'b1;
    tick(H);
    $display("sync latency check done");

    do_xfer(8'h84, 2, -1, 0, 1'b1);
    do_xfer(8'h86, 1, -1, 0, 1'b1);
    do_xfer(8'h85, 1, -1, 0, 1'b1);
    do_xfer(8'h84, 1, -1, 3, 1'b0);
    do_xfer(8'h84, 1, -1, 0, 1'b1);
    do_xfer(8'h84, 3, 0, 0, 1'b1);
    do_stop();
    $display("idle stop: stop_det pulses with no state change");
    do_reset_mid();
    do_xfer(8'h84, 1, -1, 0, 1'b1);

    for (int t = 0; t < 25; t++) begin
      logic [7:0] ab;
      int nb, da, pb;
      bit st;
      if ($urandom_range(0, 2) != 0) ab = {SA, ($urandom_range(0, 3) == 0)};
      else ab = 8'($urandom);
      nb = int'($urandom_range(0, 2));
      da = (nb > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
      pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      st = ($urandom_range(0, 3) != 0);
      do_xfer(ab, nb, da, pb, st);
    end
    if (m_busy != 0) do_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_addr_ctrl.md
Name: i2c_slave_addr_ctrl

Overview:
Front-end stage of the I2C slave, directly upstream of the data-in decoder. It synchronises the raw SCL/SDA pins and produces the SCL/SCL_prev/SDA/SDA_prev signals the decoder consumes. It detects START/STOP, receives and matches the 7-bit address byte, and drives the address ACK. It asserts enable to the decoder only while a write transfer addressed to this slave is active.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit address this slave responds to
SYNC_STAGES, 2, flops in each pin synchroniser (min 2)

Ports:
FPGA_clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
SCL_in  in  1  raw SCL pin
SDA_in  in  1  raw SDA pin
data_done  in  1  decoder "done"; ends the data phase
SCL  out  1  synchronised SCL
SCL_prev  out  1  SCL delayed one FPGA_clk
SDA  out  1  synchronised SDA
SDA_prev  out  1  SDA delayed one FPGA_clk
enable  out  1  data phase active; gates the decoder
SDA_down  out  1  1 = pull SDA low (address ACK)
start_det  out  1  one-cycle pulse on START or repeated START
stop_det  out  1  one-cycle pulse on STOP
addr_match  out  1  last received address equals SLAVE_ADDR
rw_bit  out  1  R/W bit of last address byte
bus_busy  out  1  high from START until STOP

Behaviour:
- Reset (rst=0, async): SCL, SCL_prev, SDA, SDA_prev and sync chains = 1 (idle bus). All other outputs = 0. FSM = IDLE, bit counter = 0.
- Sync: SCL/SDA = last flop of the SYNC_STAGES chain. *_prev = one further register. Latency from raw pin to SCL/SDA = SYNC_STAGES edges.
- Edge terms, all from registered signals: rise = SCL & ~SCL_prev; fall = ~SCL & SCL_prev. START = SCL & SCL_prev & SDA_prev & ~SDA. STOP = SCL & SCL_prev & ~SDA_prev & SDA.
- start_det/stop_det: registered, high exactly one cycle, on the edge after the condition is true.
- Timing requirement: SCL high and low phases each ≥ SYNC_STAGES+3 FPGA_clk periods. SDA changes only while SCL is low, except START/STOP.
- FSM states: IDLE, ADDR, ACK_ADDR, DATA, WAIT_STOP.
- IDLE: on START → ADDR, bit counter cleared, bus_busy=1.
- ADDR: on each SCL rise, shift SDA into an 8-bit shift register MSB first and increment the counter. At the 8th rise, latch addr_match = (shift[7:1]==SLAVE_ADDR) and rw_bit = shift[0].
  - At the next SCL fall: if addr_match & ~rw_bit → ACK_ADDR with SDA_down=1. Otherwise → WAIT_STOP with SDA_down=0 (NACK; reads are not supported).
- ACK_ADDR: hold SDA_down=1 through the 9th SCL rise. At the 9th SCL fall: SDA_down=0, enable=1, → DATA.
- DATA: enable=1. Data bytes and their ACKs belong to the decoder; this block keeps SDA_down=0. data_done=1 → enable=0 next cycle, → WAIT_STOP.
- WAIT_STOP: enable=0, SDA_down=0. Ignores all bits until START or STOP.
- STOP in any state: → IDLE next cycle. enable, SDA_down and bus_busy go 0; addr_match and rw_bit keep their values.
- Repeated START in any non-IDLE state: → ADDR. enable and SDA_down go 0 in the same cycle start_det pulses; counter cleared; addr_match cleared.
- START and data_done in the same cycle: START wins.
- STOP without a preceding START while in IDLE: stop_det pulses; no state change.
- rst asserted mid-transfer: immediate return to reset values; the in-flight ACK is dropped.

Test Plan:
- SLAVE_ADDR=7'h42: START, byte 0x84, then 2 data bytes, STOP → SDA_down=1 for the whole 9th SCL clock; enable rises at the 9th SCL fall; start_det and stop_det each pulse once; bus_busy falls after STOP.
- START, byte 0x86 (address 0x43) → SDA_down stays 0, addr_match=0, enable stays 0 until STOP; FSM in WAIT_STOP.
- START, byte 0x85 (address 0x42, read) → NACK (SDA_down=0), rw_bit=1, addr_match=1, enable=0.
- Matched write, then repeated START mid-byte, then byte 0x84 → enable=0 on the start_det cycle; ACK reissued on the new 9th clock; enable=1 again.
- Matched write, data_done pulsed → enable=0 next cycle; subsequent bytes get no SDA_down from this block; STOP → IDLE.
- rst=0 during the 5th address bit, then released, then full 0x84 transfer → all outputs at reset values while rst=0; the next transfer is ACKed normally.
